// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM states, forward selects, register zero.
package pipe_hazard_ctrl_pkg;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_MWAIT = 2'b01,
    ST_ERR   = 2'b10
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // Operand source for one EX read port; the younger MEM result beats WB.
  function automatic logic [1:0] fwd_select(
    input logic      mem_regwr,
    input reg_addr_t mem_rd,
    input logic      wb_regwr,
    input reg_addr_t wb_rd,
    input reg_addr_t src
  );
    if (mem_regwr && (mem_rd != REG_ZERO) && (mem_rd == src)) return FWD_MEM;
    if (wb_regwr && (wb_rd != REG_ZERO) && (wb_rd == src))    return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle between the datapath and the hazard controller.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  reg_addr_t  id_rs, id_rt;
  reg_addr_t  ex_rs, ex_rt, ex_rd;
  logic       ex_regwr, ex_memreg;
  reg_addr_t  mem_rd;
  logic       mem_regwr;
  reg_addr_t  wb_rd;
  logic       wb_regwr;
  logic       branch_taken;
  logic       mem_req, mem_ack;
  logic       cnt_clr;

  logic        pc_en, ifid_en, idex_en, exmem_en;
  logic        ifid_flush, idex_flush, memwb_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic        mem_err;
  logic [15:0] stall_cnt;

  modport master (
    output id_rs, id_rt, ex_rs, ex_rt, ex_rd, ex_regwr, ex_memreg,
           mem_rd, mem_regwr, wb_rd, wb_regwr, branch_taken,
           mem_req, mem_ack, cnt_clr,
    input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
           memwb_bubble, fwd_a, fwd_b, mem_err, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, ex_rs, ex_rt, ex_rd, ex_regwr, ex_memreg,
           mem_rd, mem_regwr, wb_rd, wb_regwr, branch_taken,
           mem_req, mem_ack, cnt_clr,
    output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
           memwb_bubble, fwd_a, fwd_b, mem_err, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX operand forwarding; purely combinational, unaffected by stalls.
module fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  reg_addr_t  ex_rs_i,
  input  reg_addr_t  ex_rt_i,
  input  reg_addr_t  mem_rd_i,
  input  logic       mem_regwr_i,
  input  reg_addr_t  wb_rd_i,
  input  logic       wb_regwr_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  assign fwd_a_o = fwd_select(mem_regwr_i, mem_rd_i, wb_regwr_i, wb_rd_i, ex_rs_i);
  assign fwd_b_o = fwd_select(mem_regwr_i, mem_rd_i, wb_regwr_i, wb_rd_i, ex_rt_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM, stall/flush generation,
// stall-cycle counter and operand forwarding.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  hz_state_e   state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        freeze;
  logic        load_use;

  assign load_use = bus.ex_memreg && bus.ex_regwr && (bus.ex_rd != REG_ZERO) &&
                    ((bus.ex_rd == bus.id_rs) || (bus.ex_rd == bus.id_rt));

  // Memory-wait FSM next state and freeze decode.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        freeze = bus.mem_req && !bus.mem_ack;
        if (freeze) begin
          state_d    = ST_MWAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_MWAIT: begin
        freeze = bus.mem_req && !bus.mem_ack;
        if (bus.mem_ack) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == TIMEOUT_W) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_ERR: begin
        freeze = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Pipeline enables and bubbles: freeze > branch flush > load-use stall.
  always_comb begin
    bus.pc_en        = 1'b1;
    bus.ifid_en      = 1'b1;
    bus.idex_en      = 1'b1;
    bus.exmem_en     = 1'b1;
    bus.ifid_flush   = 1'b0;
    bus.idex_flush   = 1'b0;
    bus.memwb_bubble = 1'b0;
    if (freeze) begin
      bus.pc_en        = 1'b0;
      bus.ifid_en      = 1'b0;
      bus.idex_en      = 1'b0;
      bus.exmem_en     = 1'b0;
      bus.memwb_bubble = 1'b1;
    end else if (bus.branch_taken) begin
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (load_use) begin
      bus.pc_en      = 1'b0;
      bus.ifid_en    = 1'b0;
      bus.idex_flush = 1'b1;
    end
  end

  // Stall counter next value: clear wins, otherwise saturating count of PC holds.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.cnt_clr)                                 stall_cnt_d = 16'd0;
    else if (!bus.pc_en && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.mem_err   = (state_q == ST_ERR);
  assign bus.stall_cnt = stall_cnt_q;

  fwd_unit u_fwd (
    .ex_rs_i     (bus.ex_rs),
    .ex_rt_i     (bus.ex_rt),
    .mem_rd_i    (bus.mem_rd),
    .mem_regwr_i (bus.mem_regwr),
    .wb_rd_i     (bus.wb_rd),
    .wb_regwr_i  (bus.wb_regwr),
    .fwd_a_o     (bus.fwd_a),
    .fwd_b_o     (bus.fwd_b)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, the memory wait-cycle limit before the error state (1..255).
REQ-002 clk  in  1  the single pipeline clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-low.
REQ-004 id_rs, id_rt  in  5 each  source register fields of the instruction in ID.
REQ-005 ex_rs, ex_rt  in  5 each  source register fields of the instruction in EX.
REQ-006 ex_rd  in  5, ex_regwr  in  1, ex_memreg  in  1  destination, write-enable and load flag of the instruction in EX.
REQ-007 mem_rd  in  5, mem_regwr  in  1  destination and write-enable of the instruction in MEM.
REQ-008 wb_rd  in  5, wb_regwr  in  1  destination and write-enable from the MEM/WB buffer outputs.
REQ-009 branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-010 mem_req  in  1, mem_ack  in  1  data-memory access request and ready from the MEM stage.
REQ-011 cnt_clr  in  1  clears the stall counter.
REQ-012 pc_en, ifid_en, idex_en, exmem_en  out  1 each  pipeline register enables.
REQ-013 ifid_flush, idex_flush, memwb_bubble  out  1 each  load-zero (bubble) controls.
REQ-014 fwd_a, fwd_b  out  2 each  EX operand forward selects: 00 register file, 10 from MEM, 01 from WB.
REQ-015 mem_err  out  1  sticky memory-timeout flag.
REQ-016 stall_cnt  out  16  count of cycles with pc_en low.

Function
REQ-017 The FSM SHALL have states RUN, MWAIT and ERR.
REQ-018 freeze = mem_req & !mem_ack in RUN or MWAIT; freeze = 1 in ERR.
REQ-019 While freeze is high, pc_en, ifid_en, idex_en and exmem_en SHALL be 0, memwb_bubble 1, and both flushes 0; this is combinational in the same cycle.
REQ-020 RUN -> MWAIT on freeze, loading wait_cnt to 1.
REQ-021 MWAIT -> RUN on mem_ack, with the pipeline advancing at that edge.
REQ-022 In MWAIT without ack, wait_cnt SHALL increment, and the FSM SHALL go MWAIT -> ERR when wait_cnt == TIMEOUT without ack.
REQ-023 ERR SHALL hold until reset, with mem_err = 1 in ERR only.
REQ-024 Branch flush: with no freeze and branch_taken high, ifid_flush = 1 and idex_flush = 1 for that cycle, all enables 1, and load-use ignored.
REQ-025 Load-use hazard: ex_memreg & ex_regwr & ex_rd != 0 & (ex_rd == id_rs | ex_rd == id_rt).
REQ-026 On load-use with no freeze and no branch, pc_en = 0, ifid_en = 0 and idex_flush = 1 for exactly that cycle.
REQ-027 Priority SHALL be freeze > branch_taken > load-use; otherwise all enables 1, flushes 0 and memwb_bubble 0.
REQ-028 fwd_a SHALL be 10 if mem_regwr & mem_rd != 0 & mem_rd == ex_rs; else 01 if wb_regwr & wb_rd != 0 & wb_rd == ex_rs; else 00.
REQ-029 fwd_b SHALL follow the same rule using ex_rt; MEM wins when both match.
REQ-030 Forwarding SHALL be combinational and independent of freeze.
REQ-031 stall_cnt SHALL increment by 1 on each cycle with pc_en = 0, saturating at 16'hFFFF.
REQ-032 cnt_clr SHALL zero stall_cnt at the next edge, taking priority over increment.

Reset
REQ-033 On rst low at a clock edge: state = RUN, wait_cnt = 0, stall_cnt = 0 and mem_err = 0.
REQ-034 Reset SHALL abort any MWAIT or ERR in progress; combinational outputs then follow inputs with state RUN.

Structure
REQ-035 A shared pipeline package SHALL hold the FSM state encoding, the forward-select constants (FWD_RF = 00, FWD_WB = 01, FWD_MEM = 10) and the register-zero constant.
REQ-036 Forwarding SHALL be one sub-module, fwd_unit, instantiated once; hazard logic, FSM and counters stay in pipe_hazard_ctrl.

Verification
REQ-037 Load-use: ex_memreg = 1, ex_regwr = 1, ex_rd = 5, id_rs = 5 -> one cycle pc_en = 0, ifid_en = 0, idex_flush = 1; stall_cnt = 1.
REQ-038 ex_rd = 0 with a matching id_rs = 0 -> no stall.
REQ-039 Forwarding: mem_rd = wb_rd = ex_rs = 7, both regwr = 1 -> fwd_a = 10; clear mem_regwr -> fwd_a = 01.
REQ-040 mem_req = 1 with ack after 3 cycles -> freeze for 3 cycles; RUN after ack; stall_cnt = 3.
REQ-041 mem_req = 1, ack never, TIMEOUT = 4 -> ERR and mem_err = 1 after the 4th MWAIT cycle.
REQ-042 Reset clears mem_err, state and stall_cnt.
REQ-043 branch_taken plus load-use plus no freeze -> both flushes 1, pc_en = 1.
REQ-044 The same case with freeze -> all enables 0.
